// File: rtl/lcb_responder.sv
// LCB-side RS-485 responder: receives 8N1 requests, answers with channel reply.
// Define LCB_RESP_CHKSUM_EN to verify request checksum and append reply checksum.
module lcb_responder #(
  parameter int          CLK_DIV   = 16,
  parameter logic [7:0]  LCB_ID    = 8'h03,
  parameter int          N_CH      = 12,
  parameter int          REPLY_GAP = 4,
  parameter int          TURN_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iRX,
  output logic       oTX,
  output logic       oDirTX,
  output logic       oDirRX,
  output logic [4:0] oChAddr,
  output logic       oChRd,
  input  logic [7:0] iChData,
  output logic [4:0] oCycle,
  output logic       oBusy,
  output logic       oFrameErr
);

`ifdef LCB_RESP_CHKSUM_EN
  localparam int NB = N_CH + 3;
`else
  localparam int NB = N_CH + 2;
`endif

  localparam logic [15:0] HALF  = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] BITC  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAPC  = 16'(REPLY_GAP * CLK_DIV);
  localparam logic [15:0] TMOC  = 16'(20 * CLK_DIV - 1);
  localparam logic [3:0]  TLAST = 4'(TURN_BITS - 1);
  localparam logic [5:0]  LASTB = 6'(NB - 1);
  localparam logic [5:0]  NCH6  = 6'(N_CH);

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    F_SYNC,
    F_ADDR,
    F_CYC,
    F_CHK,
    F_GAP,
    F_TON,
    F_SEND,
    F_TOFF
  } fr_st_t;

  rx_st_t      rst;
  fr_st_t      fst;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic [15:0] rcnt;
  logic [2:0]  rbit;
  logic [7:0]  rsh;
  logic [15:0] tmo;

  logic [7:0]  rchk;
  logic [4:0]  cyc_q;
  logic [15:0] tcnt;
  logic [15:0] tck;
  logic [3:0]  bit_i;
  logic [5:0]  byte_i;
  logic [7:0]  cur;
  logic [7:0]  txchk;
  logic [7:0]  ch_q;
  logic        rd_d1;
  logic        rd_d2;

  logic       rx_en;
  logic       in_frame;
  logic       stop_samp;
  logic       byte_ok;
  logic       stop_bad;
  logic       tmo_hit;
  logic       fetch;
  logic [7:0] nxt;

  assign rx_en    = (fst == F_SYNC) || (fst == F_ADDR) ||
                    (fst == F_CYC)  || (fst == F_CHK);
  assign in_frame = (fst == F_ADDR) || (fst == F_CYC) ||
                    (fst == F_CHK);

  assign stop_samp = (rst == R_STOP) && (rcnt == BITC);
  assign byte_ok   = stop_samp && rx_s2;
  assign stop_bad  = stop_samp && !rx_s2;
  assign tmo_hit   = in_frame && (rst == R_IDLE) && (tmo == TMOC);

  // channel k is fetched while byte k+1 is on the wire
  assign fetch = (byte_i != 6'd0) && (byte_i <= NCH6);

  always_comb begin
    nxt = txchk;
    unique case (1'b1)
      (byte_i == 6'd0): nxt = {3'b000, oCycle};
      (byte_i != 6'd0 && byte_i <= NCH6): nxt = ch_q;
      (byte_i > NCH6): nxt = txchk;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rst     <= R_IDLE;
      rcnt    <= '0;
      rbit    <= '0;
      rsh     <= '0;
      tmo     <= '0;
    end else begin
      rx_s1   <= iRX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      tmo     <= (in_frame && rst == R_IDLE) ? tmo + 16'd1 : '0;
      if (!rx_en) begin
        rst <= R_IDLE;
      end else begin
        unique case (rst)
          R_IDLE: begin
            if (rx_prev && !rx_s2) begin
              rst  <= R_START;
              rcnt <= '0;
            end
          end
          R_START: begin
            if (rcnt == HALF) begin
              rcnt <= '0;
              rbit <= '0;
              rst  <= rx_s2 ? R_IDLE : R_DATA;
            end else begin
              rcnt <= rcnt + 16'd1;
            end
          end
          R_DATA: begin
            if (rcnt == BITC) begin
              rcnt <= '0;
              rsh  <= {rx_s2, rsh[7:1]};
              if (rbit == 3'd7) rst <= R_STOP;
              else rbit <= rbit + 3'd1;
            end else begin
              rcnt <= rcnt + 16'd1;
            end
          end
          R_STOP: begin
            if (rcnt == BITC) rst <= R_IDLE;
            else rcnt <= rcnt + 16'd1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fst       <= F_SYNC;
      oTX       <= 1'b1;
      oDirTX    <= 1'b0;
      oDirRX    <= 1'b0;
      oChAddr   <= '0;
      oChRd     <= 1'b0;
      oCycle    <= '0;
      oBusy     <= 1'b0;
      oFrameErr <= 1'b0;
      rchk      <= '0;
      cyc_q     <= '0;
      tcnt      <= '0;
      tck       <= '0;
      bit_i     <= '0;
      byte_i    <= '0;
      cur       <= '0;
      txchk     <= '0;
      ch_q      <= '0;
      rd_d1     <= 1'b0;
      rd_d2     <= 1'b0;
    end else begin
      oFrameErr <= 1'b0;
      oChRd     <= 1'b0;
      rd_d1     <= oChRd;
      rd_d2     <= rd_d1;
      if (rd_d2) ch_q <= iChData;
      unique case (fst)
        F_SYNC: begin
          if (byte_ok && rsh == 8'h5A) begin
            rchk <= 8'h5A;
            fst  <= F_ADDR;
          end
        end
        F_ADDR: begin
          if (stop_bad || tmo_hit) begin
            oFrameErr <= 1'b1;
            fst       <= F_SYNC;
          end else if (byte_ok) begin
            if (rsh == LCB_ID) begin
              rchk <= rchk ^ rsh;
              fst  <= F_CYC;
            end else begin
              fst <= F_SYNC;
            end
          end
        end
        F_CYC: begin
          if (stop_bad || tmo_hit) begin
            oFrameErr <= 1'b1;
            fst       <= F_SYNC;
          end else if (byte_ok) begin
            rchk  <= rchk ^ rsh;
            cyc_q <= rsh[4:0];
`ifdef LCB_RESP_CHKSUM_EN
            fst   <= F_CHK;
`else
            oCycle <= rsh[4:0];
            oBusy  <= 1'b1;
            tcnt   <= '0;
            fst    <= F_GAP;
`endif
          end
        end
        F_CHK: begin
          if (stop_bad || tmo_hit) begin
            oFrameErr <= 1'b1;
            fst       <= F_SYNC;
          end else if (byte_ok) begin
            if (rsh == rchk) begin
              oCycle <= cyc_q;
              oBusy  <= 1'b1;
              tcnt   <= '0;
              fst    <= F_GAP;
            end else begin
              oFrameErr <= 1'b1;
              fst       <= F_SYNC;
            end
          end
        end
        F_GAP: begin
          if (tcnt == GAPC) begin
            oDirTX <= 1'b1;
            oDirRX <= 1'b1;
            oTX    <= 1'b1;
            tck    <= '0;
            bit_i  <= '0;
            fst    <= F_TON;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        F_TON: begin
          if (tck == BITC) begin
            tck <= '0;
            if (bit_i == TLAST) begin
              oTX    <= 1'b0;
              cur    <= 8'hA5;
              txchk  <= 8'hA5;
              byte_i <= '0;
              bit_i  <= '0;
              fst    <= F_SEND;
            end else begin
              bit_i <= bit_i + 4'd1;
            end
          end else begin
            tck <= tck + 16'd1;
          end
        end
        F_SEND: begin
          if (tck == BITC) begin
            tck <= '0;
            if (bit_i == 4'd9) begin
              bit_i <= '0;
              if (byte_i == LASTB) begin
                oTX <= 1'b1;
                fst <= F_TOFF;
              end else begin
                oTX    <= 1'b0;
                cur    <= nxt;
                txchk  <= txchk ^ nxt;
                byte_i <= byte_i + 6'd1;
              end
            end else begin
              bit_i <= bit_i + 4'd1;
              oTX   <= (bit_i == 4'd8) ? 1'b1 : cur[bit_i[2:0]];
              if (bit_i == 4'd8 && fetch) begin
                oChRd   <= 1'b1;
                oChAddr <= 5'(byte_i - 6'd1);
              end
            end
          end else begin
            tck <= tck + 16'd1;
          end
        end
        F_TOFF: begin
          if (tck == BITC) begin
            tck <= '0;
            if (bit_i == TLAST) begin
              oDirTX <= 1'b0;
              oDirRX <= 1'b0;
              oBusy  <= 1'b0;
              fst    <= F_SYNC;
            end else begin
              bit_i <= bit_i + 4'd1;
            end
          end else begin
            tck <= tck + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcb_responder.sv
// Self-checking bench for lcb_responder: UART driver/decoder plus reply model.
// Builds for both settings of LCB_RESP_CHKSUM_EN.
module tb_lcb_responder;
  localparam int D    = 16;
  localparam int NCH  = 4;
  localparam int GAP  = 4;
  localparam int TURN = 2;
`ifdef LCB_RESP_CHKSUM_EN
  localparam int NB = NCH + 3;
`else
  localparam int NB = NCH + 2;
`endif
  // stop sample lands D/2 into the stop bit, after a 2-FF sync + edge detect
  localparam int NOM = GAP * D + 1 + D / 2 + 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       iRX;
  logic       oTX;
  logic       oDirTX;
  logic       oDirRX;
  logic [4:0] oChAddr;
  logic       oChRd;
  logic [7:0] iChData;
  logic [4:0] oCycle;
  logic       oBusy;
  logic       oFrameErr;

  logic [7:0] mem [32];
  logic [7:0] d1 = 8'h00;
  logic [7:0] d2 = 8'h00;
  logic       dir_q = 1'b0;

  int clk_n = 0, rise_at = 0, rises = 0, dir_hi = 0;
  int errs = 0, reads = 0, stop_at = 0;
  int e0, r0, h0, rd0;
  int total = 0, bad = 0;

  lcb_responder #(
    .CLK_DIV(D), .LCB_ID(8'h03), .N_CH(NCH),
    .REPLY_GAP(GAP), .TURN_BITS(TURN)
  ) dut (
    .clk(clk), .reset(reset_n), .iRX(iRX),
    .oTX(oTX), .oDirTX(oDirTX), .oDirRX(oDirRX),
    .oChAddr(oChAddr), .oChRd(oChRd), .iChData(iChData),
    .oCycle(oCycle), .oBusy(oBusy), .oFrameErr(oFrameErr)
  );

  always #5 clk = ~clk;

  assign iChData = d2;

  // channel buffer with 2-clock read latency plus link activity counters
  always @(posedge clk) begin
    clk_n <= clk_n + 1;
    dir_q <= oDirTX;
    if (oDirTX && !dir_q) begin
      rise_at <= clk_n;
      rises   <= rises + 1;
    end
    if (oDirTX) dir_hi <= dir_hi + 1;
    if (oFrameErr) errs <= errs + 1;
    if (oChRd) begin
      reads <= reads + 1;
      d1    <= mem[oChAddr];
    end
    d2 <= d1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic snap();
    e0 = errs; r0 = rises; h0 = dir_hi; rd0 = reads;
  endtask

  task automatic tx_bit(input logic v);
    iRX = v;
    repeat (D) @(posedge clk);
    #1;
  endtask

  task automatic tx_byte(input logic [7:0] b, input logic sv);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
    stop_at = clk_n;
    tx_bit(sv);
    iRX = 1'b1;
  endtask

  task automatic send_req(input logic [7:0] a, input logic [7:0] c,
                          input logic [7:0] x);
    tx_byte(8'h5A, 1'b1);
    tx_byte(a, 1'b1);
    tx_byte(c, 1'b1);
`ifdef LCB_RESP_CHKSUM_EN
    tx_byte(x, 1'b1);
`else
    if (x == 8'h00) iRX = 1'b1;
`endif
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 40 * D; i++) begin
      @(negedge clk);
      if (oTX === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    repeat (D / 2) @(negedge clk);
    if (oTX !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (D) @(negedge clk);
      b[i] = oTX;
    end
    repeat (D) @(negedge clk);
    if (oTX !== 1'b1) ok = 1'b0;
  endtask

  task automatic expect_reply(input logic [7:0] c, input int n);
    logic [7:0] e[$];
    logic [7:0] b;
    logic [7:0] x;
    bit ok;
    bit seen;
    e.push_back(8'hA5);
    e.push_back({3'b000, c[4:0]});
    for (int k = 0; k < NCH; k++) e.push_back(mem[k]);
`ifdef LCB_RESP_CHKSUM_EN
    x = 8'h00;
    foreach (e[i]) x ^= e[i];
    e.push_back(x);
`endif
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (oDirTX === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("dir_rise", 32'(seen), 1);
    if (!seen) return;
    chk("busy_on", 32'(oBusy), 1);
    chk("dirrx_on", 32'(oDirRX), 1);
    chk("cycle", 32'(oCycle), 32'(c[4:0]));
    for (int i = 0; i < n; i++) begin
      rx_byte(b, ok);
      chk($sformatf("framed%0d", i), 32'(ok), 1);
      chk($sformatf("byte%0d", i), 32'(b), 32'(e[i]));
    end
    chk_rng("rise_gap", rise_at - stop_at, NOM - 2, NOM + 2);
    if (n < NB) return;
    seen = 1'b0;
    for (int i = 0; i < 8 * D; i++) begin
      @(negedge clk);
      if (oDirTX === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("dir_fall", 32'(seen), 1);
    chk("dir_len", 32'(dir_hi - h0), 32'((2 * TURN + 10 * NB) * D));
    chk("busy_off", 32'(oBusy), 0);
    chk("dirrx_off", 32'(oDirRX), 0);
    chk("no_err", 32'(errs - e0), 0);
    chk("reads", 32'(reads - rd0), NCH);
    chk("rises", 32'(rises - r0), 1);
  endtask

  task automatic good_txn(input logic [7:0] c);
    snap();
    send_req(8'h03, c, 8'h5A ^ 8'h03 ^ c);
    expect_reply(c, NB);
  endtask

  task automatic quiet(input int bits);
    repeat (bits * D) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] c;
    reset_n = 1'b0;
    iRX = 1'b1;
    for (int k = 0; k < 32; k++) mem[k] = 8'h10 + 8'(k);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(oTX), 1);
    chk("rst_dirtx", 32'(oDirTX), 0);
    chk("rst_dirrx", 32'(oDirRX), 0);
    chk("rst_addr", 32'(oChAddr), 0);
    chk("rst_rd", 32'(oChRd), 0);
    chk("rst_cycle", 32'(oCycle), 0);
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_err", 32'(oFrameErr), 0);
    reset_n = 1'b1;
    quiet(4);

    good_txn(8'h07);

    snap();
    send_req(8'h04, 8'h07, 8'h59);
    quiet(60);
    chk("other_rises", 32'(rises - r0), 0);
    chk("other_err", 32'(errs - e0), 0);
    chk("other_reads", 32'(reads - rd0), 0);
    chk("other_cycle", 32'(oCycle), 7);

`ifdef LCB_RESP_CHKSUM_EN
    snap();
    send_req(8'h03, 8'h07, 8'h5F);
    quiet(60);
    chk("badck_err", 32'(errs - e0), 1);
    chk("badck_rises", 32'(rises - r0), 0);
    good_txn(8'h0B);
`endif

    snap();
    tx_byte(8'h5A, 1'b1);
    tx_byte(8'h03, 1'b0);
    quiet(6);
    chk("stop_err", 32'(errs - e0), 1);
    chk("stop_rises", 32'(rises - r0), 0);

    snap();
    iRX = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    iRX = 1'b1;
    quiet(6);
    chk("glitch_err", 32'(errs - e0), 0);
    good_txn(8'h15);

    snap();
    tx_byte(8'h5A, 1'b1);
    tx_byte(8'h03, 1'b1);
    quiet(25);
    chk("tmo_err", 32'(errs - e0), 1);
    tx_byte(8'h07, 1'b1);
    tx_byte(8'h5E, 1'b1);
    quiet(60);
    chk("tmo_rises", 32'(rises - r0), 0);
    chk("tmo_err2", 32'(errs - e0), 1);
    chk("tmo_reads", 32'(reads - rd0), 0);

    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < NCH; k++) mem[k] = 8'($urandom);
      c = 8'($urandom);
      good_txn(c);
    end

    for (int k = 0; k < NCH; k++) mem[k] = 8'($urandom);
    c = 8'($urandom);
    snap();
    send_req(8'h03, c, 8'h5A ^ 8'h03 ^ c);
    expect_reply(c, 2);
    repeat (3 * D) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_tx", 32'(oTX), 1);
    chk("mid_dirtx", 32'(oDirTX), 0);
    chk("mid_dirrx", 32'(oDirRX), 0);
    chk("mid_busy", 32'(oBusy), 0);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    quiet(2);
    c = 8'($urandom);
    good_txn(c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
